// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad path: state encoding, key-to-matrix map,
// and the wired-AND row response of a single closed switch.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BOUNCE_PRESS,
        ST_HELD,
        ST_BOUNCE_RELEASE,
        ST_DONE
    } state_t;

    localparam logic [3:0] ROW_IDLE = 4'hF;

    // Indexed by key code: row 0 = 1 2 3 A, row 1 = 4 5 6 B, row 2 = 7 8 9 C, row 3 = 0 F E D
    localparam logic [1:0] KEY_ROW [16] = '{
        2'd3, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
        2'd2, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3
    };
    localparam logic [1:0] KEY_COL [16] = '{
        2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0,
        2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1
    };

    function automatic logic [3:0] row_response(
        input logic [3:0] key,
        input logic [3:0] col_n,
        input logic       closed
    );
        logic [3:0] resp;
        resp = ROW_IDLE;
        if (closed && !col_n[KEY_COL[key]]) begin
            resp[KEY_ROW[key]] = 1'b0;
        end
        return resp;
    endfunction

endpackage

// File: rtl/keypad_emulator_bounce_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that supplies pseudo-random contact
// states during bounce; free-running across requests, only reset reseeds it.
module bounce_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic clk,
    input  logic rst,
    input  logic adv,
    output logic bit_nxt
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic       fb;

    assign fb      = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign bit_nxt = fb;

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv) begin
            lfsr_d = {lfsr_q[6:0], fb};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// Keypad-side emulation of a 4x4 switch matrix: answers the scanner's column
// drive on the row lines with a timed press, hold and contact bounce.
//
// state              | meaning
// ST_IDLE            | waiting for press_req, contact open
// ST_BOUNCE_PRESS    | contact follows LFSR while closing
// ST_HELD            | contact closed for the requested hold time
// ST_BOUNCE_RELEASE  | contact follows LFSR while opening
// ST_DONE            | one-cycle completion pulse, contact open
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int         CLK_FREQ    = 50_000_000,
    parameter int         BOUNCE_MS   = 2,
    parameter int         BOUNCE_STEP = 2500,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    input  logic [3:0] key_code,
    input  logic [7:0] hold_ms,
    input  logic       press_req,
    output logic       busy,
    output logic       done,
    output logic       contact
);

    localparam int TICKS_PER_MS = CLK_FREQ / 1000;
    localparam int BNC_TICKS    = BOUNCE_MS * TICKS_PER_MS;
    localparam int MAX_MS       = (BOUNCE_MS > 255) ? BOUNCE_MS : 255;
    localparam int CNT_W        = $clog2(MAX_MS * TICKS_PER_MS + 1);
    localparam int STEP_W       = (BOUNCE_STEP > 1) ? $clog2(BOUNCE_STEP) : 1;

    localparam logic [CNT_W-1:0]  BNC_LOAD  = CNT_W'(BNC_TICKS - 1);
    localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(BOUNCE_STEP - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                contact_q, contact_d;
    logic [3:0]          key_q, key_d;
    logic [7:0]          hold_q, hold_d;
    logic [3:0]          row_q, row_d;

    logic                lfsr_adv;
    logic                lfsr_bit_nxt;
    logic [7:0]          hold_in_eff;
    logic [7:0]          hold_src;
    logic [CNT_W-1:0]    hold_load;

    bounce_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .adv     (lfsr_adv),
        .bit_nxt (lfsr_bit_nxt)
    );

    // Without bounce the hold counter loads on accept, before hold_q is valid.
    assign hold_in_eff = (hold_ms == 8'd0) ? 8'd1 : hold_ms;
    assign hold_src    = (state_q == ST_IDLE) ? hold_in_eff : hold_q;
    assign hold_load   = CNT_W'(hold_src) * CNT_W'(TICKS_PER_MS) - CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        step_d    = step_q;
        contact_d = contact_q;
        key_d     = key_q;
        hold_d    = hold_q;
        lfsr_adv  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                contact_d = 1'b0;
                if (press_req) begin
                    key_d  = key_code;
                    hold_d = hold_in_eff;
                    if (BOUNCE_MS == 0) begin
                        state_d   = ST_HELD;
                        cnt_d     = hold_load;
                        contact_d = 1'b1;
                    end else begin
                        state_d = ST_BOUNCE_PRESS;
                        cnt_d   = BNC_LOAD;
                        step_d  = STEP_LOAD;
                    end
                end
            end
            ST_BOUNCE_PRESS, ST_BOUNCE_RELEASE: begin
                cnt_d = cnt_q - 1'b1;
                if (step_q == '0) begin
                    lfsr_adv  = 1'b1;
                    contact_d = lfsr_bit_nxt;
                    step_d    = STEP_LOAD;
                end else begin
                    step_d = step_q - 1'b1;
                end
                // Exit overrides any bounce update landing on the same cycle.
                if (cnt_q == '0) begin
                    if (state_q == ST_BOUNCE_PRESS) begin
                        state_d   = ST_HELD;
                        cnt_d     = hold_load;
                        contact_d = 1'b1;
                    end else begin
                        state_d   = ST_DONE;
                        contact_d = 1'b0;
                    end
                end
            end
            ST_HELD: begin
                cnt_d     = cnt_q - 1'b1;
                contact_d = 1'b1;
                if (cnt_q == '0) begin
                    if (BOUNCE_MS == 0) begin
                        state_d   = ST_DONE;
                        contact_d = 1'b0;
                    end else begin
                        state_d = ST_BOUNCE_RELEASE;
                        cnt_d   = BNC_LOAD;
                        step_d  = STEP_LOAD;
                    end
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                contact_d = 1'b0;
            end
            default: begin
                state_d   = ST_IDLE;
                contact_d = 1'b0;
            end
        endcase
    end

    assign row_d = row_response(key_q, col_in, contact_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            step_q    <= '0;
            contact_q <= 1'b0;
            key_q     <= 4'h0;
            hold_q    <= 8'h00;
            row_q     <= ROW_IDLE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            contact_q <= contact_d;
            key_q     <= key_d;
            hold_q    <= hold_d;
            row_q     <= row_d;
        end
    end

    assign row_out = row_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign contact = contact_q;

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Behavioural-synthesizable model of the 4x4 Pmod keypad, seen from the keypad side of the row/column interface. It watches the active-low column drive from the on-board scanner and answers on the row lines as a real switch matrix would, including timed press, hold and contact bounce. It sits on the keypad connector in loopback/self-test builds so the scanner, debounce and pulse logic can be exercised without a human pressing keys.

## Interface
- CLK_FREQ, 50_000_000: clock frequency in Hz; TICKS_PER_MS = CLK_FREQ/1000.
- BOUNCE_MS, 2: bounce duration in ms at press and at release; 0 disables bounce.
- BOUNCE_STEP, 2500: cycles between bounce contact updates; must be ≥1.
- LFSR_SEED, 8'hA5: nonzero reset value of the bounce LFSR.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- col_in  in  4  column drive from the scanner, active-low, index 0 = leftmost column.
- row_out  out  4  row response, active-low, index 0 = top row; idle 4'hF.
- key_code  in  4  key to press, sampled on accept.
- hold_ms  in  8  closed-contact hold time in ms, sampled on accept.
- press_req  in  1  request a press/release cycle.
- busy  out  1  high from accept until the cycle completes.
- done  out  1  one-cycle pulse at completion.
- contact  out  1  current internal switch state; 1 = closed.

## Operation
- Key map: row 0 = 1 2 3 A, row 1 = 4 5 6 B, row 2 = 7 8 9 C, row 3 = 0 F E D; columns 0..3 left to right.
- Row response, registered: row_out[r] <= 0 iff contact=1, r = row(key), and col_in[col(key)] = 0; all other bits 1. Several columns low at once still produce the correct wired-AND result.
- FSM states: IDLE, BOUNCE_PRESS, HELD, BOUNCE_RELEASE, DONE.
- IDLE: press_req=1 latches key_code and hold_ms (0 is treated as 1), then moves to BOUNCE_PRESS, or to HELD if BOUNCE_MS=0.
- BOUNCE_PRESS / BOUNCE_RELEASE: last BOUNCE_MS*TICKS_PER_MS cycles. Every BOUNCE_STEP cycles the LFSR advances and contact takes LFSR bit 0.
- Bounce exit: leaving BOUNCE_PRESS forces contact=1; leaving BOUNCE_RELEASE forces contact=0.
- LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1. It never reaches zero and is not reset between requests.
- HELD: contact=1 for hold_ms*TICKS_PER_MS cycles, then moves to BOUNCE_RELEASE, or to DONE if BOUNCE_MS=0.
- DONE: one cycle, done=1 and contact=0, then IDLE.
- press_req while busy is ignored; no queueing.

## Timing
- Reset values: row_out=4'hF, busy=0, done=0, contact=0, state IDLE, LFSR=LFSR_SEED, counters 0.
- rst during any state aborts the press immediately: the next cycle is the reset state, and done does not pulse.
- Accept at cycle N means busy=1 from N+1.
- With BOUNCE_MS=0: contact=1 for cycles N+1 .. N+hold_ms*TICKS_PER_MS; done=1 on the following cycle; busy falls in the cycle after done.
- row_out lags col_in and contact by exactly one cycle.
- The ms counter is a down-counter of width clog2(255*TICKS_PER_MS+1); no wrap is possible.

## Structure
- Package keypad_pkg holds the state enum typedef, the KEY_ROW and KEY_COL constant arrays (16 x 2 bits each), and the idle value 4'hF. The scanner side of the keypad path shares this package.
- One sub-module, bounce_lfsr: 8-bit LFSR with an advance enable and a seed parameter.
- The FSM, counters and row response stay in keypad_emulator.

## Test plan
All scenarios use CLK_FREQ=10_000, giving 10 cycles/ms.
- Reset: rst held 3 cycles with col_in=4'h0 → row_out=4'hF, busy=0, contact=0 throughout and after release.
- Basic press, BOUNCE_MS=0, key_code=4'h5, hold_ms=3: rotate col_in through 4'hE, 4'hD, 4'hB, 4'h7 → row_out=4'hD only one cycle after col_in=4'hD, only while contact=1; contact high for 30 cycles; done pulses once.
- Map sweep: for all 16 key codes, hold col(key) low → row_out has 0 exactly at row(key); key 4'hE gives row 3, col 2.
- Bounce, BOUNCE_MS=1, BOUNCE_STEP=2: contact toggles only on 2-cycle boundaries; contact=1 at BOUNCE_PRESS exit and 0 at BOUNCE_RELEASE exit; total busy = 10+hold+10+1 cycles.
- Request while busy, and hold_ms=0: a second press_req mid-HELD leaves key and timing unchanged; hold_ms=0 holds for 10 cycles.
- Mid-operation reset: rst during HELD → row_out=4'hF the next cycle, busy=0, no done pulse; a new press_req afterwards is accepted normally.
